// File: rtl/regfile_burst_reader_if.sv
// Read-port and output-stream signals of the register-file burst reader.
// The reader is the master; the register file plus downstream consumer form the slave side.
interface regfile_burst_reader_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] radd;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output radd,
      input  rdata,
      output out_data,
      output out_valid,
      input  out_ready,
      output out_last
   );

   modport slave (
      input  radd,
      output rdata,
      input  out_data,
      input  out_valid,
      output out_ready,
      input  out_last
   );
endinterface

// File: rtl/regfile_burst_reader.sv
// Burst reader for the 16x8 register file: streams length consecutive entries
// (wrapping at the top of the file) on a valid/ready stream, then pulses done.
module regfile_burst_reader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     length,
   output logic                busy,
   output logic                done,
   regfile_burst_reader_if.master bus
);

   localparam int             DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] MAX_LEN = DEPTH[ADDR_W:0];

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W:0]   remaining_r;
   logic [DATA_W-1:0] data_r;
   logic              valid_r;
   logic              last_r;
   logic              busy_r;
   logic              done_r;
   logic [ADDR_W:0]   eff_len_s;

   assign eff_len_s = (length > MAX_LEN) ? MAX_LEN : length;

   // The register file is read combinationally, so the address must lead the capture edge.
   assign bus.radd      = (state_r == IDLE) ? base_addr : addr_r;
   assign bus.out_data  = data_r;
   assign bus.out_valid = valid_r;
   assign bus.out_last  = last_r;
   assign busy          = busy_r;
   assign done          = done_r;

   // Burst FSM: captures one word per accepted beat and holds the word while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         addr_r      <= {ADDR_W{1'b0}};
         remaining_r <= {(ADDR_W+1){1'b0}};
         data_r      <= {DATA_W{1'b0}};
         valid_r     <= 1'b0;
         last_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start && (length != {(ADDR_W+1){1'b0}})) begin
                  data_r      <= bus.rdata;
                  valid_r     <= 1'b1;
                  last_r      <= (eff_len_s == {{ADDR_W{1'b0}}, 1'b1});
                  addr_r      <= base_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                  remaining_r <= eff_len_s - {{ADDR_W{1'b0}}, 1'b1};
                  busy_r      <= 1'b1;
                  state_r     <= STREAM;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            STREAM: begin
               if (bus.out_ready && !last_r) begin
                  data_r      <= bus.rdata;
                  addr_r      <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  remaining_r <= remaining_r - {{ADDR_W{1'b0}}, 1'b1};
                  last_r      <= (remaining_r == {{ADDR_W{1'b0}}, 1'b1});
               end else if (bus.out_ready && last_r) begin
                  valid_r <= 1'b0;
                  last_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  state_r <= STREAM;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               valid_r <= 1'b0;
               last_r  <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_burst_reader.sv
// Directed bench for regfile_burst_reader with a behavioural 16x8 register file.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_regfile_burst_reader;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] base_addr;
   logic [4:0] length;
   logic       busy;
   logic       done;
   logic [7:0] mem [16];
   int         checks;
   int         failures;

   regfile_burst_reader_if #(.DATA_W(8), .ADDR_W(4)) bus ();

   regfile_burst_reader #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   assign bus.rdata = mem[bus.radd];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called on the first falling edge after the start edge; out_ready must be 1.
   task automatic stream_expect(input logic [3:0] b, input int n);
      logic [3:0] idx;
      for (int i = 0; i < n; i++) begin
         idx = b + 4'(i);
         chk("beat_valid", 32'(bus.out_valid), 32'd1);
         chk("beat_data",  32'(bus.out_data),  32'(8'h10 + {4'h0, idx}));
         chk("beat_last",  32'(bus.out_last),  (i == n - 1) ? 32'd1 : 32'd0);
         chk("beat_busy",  32'(busy),          32'd1);
         chk("beat_done",  32'(done),          32'd0);
         @(negedge clk);
      end
      chk("done_pulse", 32'(done),          32'd1);
      chk("done_busy",  32'(busy),          32'd1);
      chk("done_valid", 32'(bus.out_valid), 32'd0);
      chk("done_last",  32'(bus.out_last),  32'd0);
      @(negedge clk);
      chk("idle_done",  32'(done),          32'd0);
      chk("idle_busy",  32'(busy),          32'd0);
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b0;
      start         = 1'b0;
      base_addr     = 4'd0;
      length        = 5'd0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);

      // Reset state
      @(negedge clk);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data",  32'(bus.out_data),  32'd0);
      chk("rst_last",  32'(bus.out_last),  32'd0);
      chk("rst_busy",  32'(busy),          32'd0);
      chk("rst_done",  32'(done),          32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // base=2 length=4: 12,13,14,15
      base_addr = 4'd2; length = 5'd4; start = 1'b1;
      #1 chk("idle_radd", 32'(bus.radd), 32'd2);
      @(negedge clk);
      start = 1'b0;
      stream_expect(4'd2, 4);

      // base=14 length=4 wraps: 1E,1F,10,11
      base_addr = 4'd14; length = 5'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stream_expect(4'd14, 4);

      // base=0 length=3 with 3 stalled cycles on the first beat
      bus.out_ready = 1'b0;
      base_addr = 4'd0; length = 5'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_data",  32'(bus.out_data),  32'h10);
         chk("stall_last",  32'(bus.out_last),  32'd0);
         chk("stall_radd",  32'(bus.radd),      32'd1);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      stream_expect(4'd0, 3);

      // length=0 is a no-op
      base_addr = 4'd7; length = 5'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("zero_valid", 32'(bus.out_valid), 32'd0);
         chk("zero_busy",  32'(busy),          32'd0);
         chk("zero_done",  32'(done),          32'd0);
         @(negedge clk);
      end

      // length=20 clamps to 16 beats, wrapping back to the base
      base_addr = 4'd3; length = 5'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stream_expect(4'd3, 16);

      // start held high during STREAM/DONE is ignored
      base_addr = 4'd8; length = 5'd4; start = 1'b1;
      @(negedge clk);
      base_addr = 4'd0; length = 5'd2;
      stream_expect(4'd8, 4);
      start = 1'b0;
      @(negedge clk);
      chk("ignore_idle_valid", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset mid-burst
      base_addr = 4'd0; length = 5'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst_data", 32'(bus.out_data), 32'h11);
      base_addr = 4'd9;
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_data",  32'(bus.out_data),  32'd0);
      chk("arst_last",  32'(bus.out_last),  32'd0);
      chk("arst_busy",  32'(busy),          32'd0);
      chk("arst_radd",  32'(bus.radd),      32'd9);
      @(negedge clk);
      chk("arst_done", 32'(done), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      base_addr = 4'd5; length = 5'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stream_expect(4'd5, 2);

      // Write to entry 5 while the beat for entry 4 is stalled
      bus.out_ready = 1'b0;
      base_addr = 4'd4; length = 5'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("wr_beat0", 32'(bus.out_data), 32'h14);
      mem[5] = 8'hAA;
      @(negedge clk);
      chk("wr_hold",  32'(bus.out_data),  32'h14);
      chk("wr_valid", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("wr_beat1", 32'(bus.out_data), 32'hAA);
      chk("wr_last",  32'(bus.out_last), 32'd1);
      @(negedge clk);
      chk("wr_done", 32'(done), 32'd1);
      mem[5] = 8'h15;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
